// File: rtl/fft32_if.sv
// fft32_if: sample-in / bin-out bus of the 32-point FFT
interface fft32_if;
   logic signed [15:0] data_i_r, data_i_i, data_o_r, data_o_i;
   logic               res_ready;
   modport master (output data_i_r, data_i_i, input data_o_r, data_o_i, res_ready);
   modport slave (input data_i_r, data_i_i, output data_o_r, data_o_i, res_ready);
endinterface

// File: rtl/fft32_top.sv
// fft32_top: streaming 32-point radix-2 DIT FFT, bit-reversed load, ping-pong banks,
// one butterfly per clock, natural-order result burst flagged by res_ready
module fft32_top (
   input logic    clk,
   input logic    reset,
   fft32_if.slave bus
);
   typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;
   localparam logic signed [15:0] tw_r [16] = '{
      16'sd16384, 16'sd16069, 16'sd15137, 16'sd13623, 16'sd11585, 16'sd9102, 16'sd6270, 16'sd3196,
      16'sd0, -16'sd3196, -16'sd6270, -16'sd9102, -16'sd11585, -16'sd13623, -16'sd15137, -16'sd16069};
   localparam logic signed [15:0] tw_i [16] = '{
      16'sd0, -16'sd3196, -16'sd6270, -16'sd9102, -16'sd11585, -16'sd13623, -16'sd15137, -16'sd16069,
      -16'sd16384, -16'sd16069, -16'sd15137, -16'sd13623, -16'sd11585, -16'sd9102, -16'sd6270, -16'sd3196};
   state_t state, state_nx;
   logic [6:0] cnt, cnt_nx;
   logic last, rd_a;
   logic [2:0] s;
   logic [3:0] k;
   logic [4:0] m, lo, p, q, rev;
   logic signed [15:0] a_r [32], a_i [32], b_r [32], b_i [32];
   logic signed [15:0] x0_r, x0_i, x1_r, x1_i, w_r, w_i, t_r, t_i;
   logic signed [32:0] m_r, m_i;
   // during COMPUTE cnt = {stage, butterfly}; even stages read bank A, odd read bank B
   assign s    = cnt[6:4];
   assign m    = (5'd1 << s) - 5'd1;
   assign lo   = {1'b0, cnt[3:0]} & m;
   assign p    = (({1'b0, cnt[3:0]} & ~m) << 1) | lo;
   assign q    = p | (5'd1 << s);
   assign k    = 4'(lo << (3'd4 - s));
   assign rd_a = ~s[0];
   assign rev  = {cnt[0], cnt[1], cnt[2], cnt[3], cnt[4]};
   assign x0_r = rd_a ? a_r[p] : b_r[p];
   assign x0_i = rd_a ? a_i[p] : b_i[p];
   assign x1_r = rd_a ? a_r[q] : b_r[q];
   assign x1_i = rd_a ? a_i[q] : b_i[q];
   assign w_r  = tw_r[k];
   assign w_i  = tw_i[k];
   assign m_r  = 33'(x1_r) * 33'(w_r) - 33'(x1_i) * 33'(w_i) + 33'sd8192;
   assign m_i  = 33'(x1_r) * 33'(w_i) + 33'(x1_i) * 33'(w_r) + 33'sd8192;
   assign t_r  = m_r[29:14];
   assign t_i  = m_i[29:14];
   assign last = cnt == (state == COMPUTE ? 7'd79 : 7'd31);
   always_comb begin
      state_nx = state;
      cnt_nx   = last ? 7'd0 : cnt + 7'd1;
      if (last) state_nx = state == LOAD ? COMPUTE : state == COMPUTE ? OUTPUT : LOAD;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= LOAD;
         cnt           <= '0;
         bus.res_ready <= 1'b0;
         bus.data_o_r  <= '0;
         bus.data_o_i  <= '0;
      end else begin
         state         <= state_nx;
         cnt           <= cnt_nx;
         bus.res_ready <= state == OUTPUT;
         bus.data_o_r  <= state == OUTPUT ? b_r[cnt[4:0]] : '0;
         bus.data_o_i  <= state == OUTPUT ? b_i[cnt[4:0]] : '0;
      end
   end
   // sample banks carry no reset; every slot is rewritten before it is read
   always_ff @(posedge clk) begin
      if (state == LOAD) begin
         a_r[rev] <= bus.data_i_r;
         a_i[rev] <= bus.data_i_i;
      end else if (state == COMPUTE && rd_a) begin
         b_r[p] <= x0_r + t_r;
         b_i[p] <= x0_i + t_i;
         b_r[q] <= x0_r - t_r;
         b_i[q] <= x0_i - t_i;
      end else if (state == COMPUTE) begin
         a_r[p] <= x0_r + t_r;
         a_i[p] <= x0_i + t_i;
         a_r[q] <= x0_r - t_r;
         a_i[q] <= x0_i - t_i;
      end
   end
endmodule

// File: tb/tb_fft32_top.sv
// tb_fft32_top: spec patterns and random frames checked bin-by-bin against a direct DFT model
module tb_fft32_top;
   logic clk = 1'b0, rst_n = 1'b0;
   fft32_if bus ();
   fft32_top dut (.clk(clk), .reset(rst_n), .bus(bus.slave));
   always #5 clk = ~clk;

   typedef struct { real r; real i; int tol; } bin_t;
   bin_t exp_q[$];
   int tests = 0, fails = 0, cyc = 0, last_cyc = -1000, run = 0;
   int in_r [32], in_i [32];
   real mr [32], mi [32];
   logic prev_rdy = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input real act, input real req, input real tol);
      tests++;
      if (act > req + tol || act < req - tol) begin
         fails++;
         $display("FAIL %s: got %0.2f, want %0.2f (+-%0.2f)", name, act, req, tol);
      end
   endtask

   // plain DFT: X[k] = sum x[n] * exp(-j*2*pi*n*k/32)
   task automatic model(input int tol);
      real sr, si, a;
      for (int k = 0; k < 32; k++) begin
         sr = 0.0;
         si = 0.0;
         for (int n = 0; n < 32; n++) begin
            a = 2.0 * 3.14159265358979323846 * real'((n * k) % 32) / 32.0;
            sr += in_r[n] * $cos(a) + in_i[n] * $sin(a);
            si += in_i[n] * $cos(a) - in_r[n] * $sin(a);
         end
         mr[k] = sr;
         mi[k] = si;
         exp_q.push_back('{sr, si, tol});
      end
   endtask

   task automatic load_frame(input int tol);
      model(tol);
      for (int n = 0; n < 32; n++) begin
         bus.data_i_r = 16'(in_r[n]);
         bus.data_i_i = 16'(in_i[n]);
         @(posedge clk);
         #1;
      end
      last_cyc = cyc;
      bus.data_i_r = 16'($urandom);
      bus.data_i_i = 16'($urandom);
   endtask

   task automatic fill_random();
      for (int n = 0; n < 32; n++) begin
         in_r[n] = int'($urandom_range(400)) - 200;
         in_i[n] = int'($urandom_range(400)) - 200;
      end
   endtask

   always @(negedge clk) begin
      bin_t e;
      if (!rst_n) begin
         check("rst_out_r", real'(bus.data_o_r), 0.0, 0.0);
         check("rst_out_i", real'(bus.data_o_i), 0.0, 0.0);
         check("rst_ready", real'(bus.res_ready), 0.0, 0.0);
         run <= 0;
      end else if (bus.res_ready) begin
         if (!prev_rdy) check("latency", real'(cyc - last_cyc), 81.0, 0.0);
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_bin: res_ready high with no frame pending");
         end else begin
            e = exp_q.pop_front();
            check($sformatf("bin%0d_r", run), real'(bus.data_o_r), e.r, real'(e.tol));
            check($sformatf("bin%0d_i", run), real'(bus.data_o_i), e.i, real'(e.tol));
         end
         run <= run + 1;
      end else begin
         check("idle_out_r", real'(bus.data_o_r), 0.0, 0.0);
         check("idle_out_i", real'(bus.data_o_i), 0.0, 0.0);
         if (prev_rdy) check("burst_len", real'(run), 32.0, 0.0);
         run <= 0;
      end
      prev_rdy <= bus.res_ready;
   end

   initial begin
      bus.data_i_r = '0;
      bus.data_i_i = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int n = 0; n < 32; n++) begin
         in_r[n] = 127;
         in_i[n] = 0;
      end
      load_frame(1);
      check("model_const_x0_r", mr[0], 4064.0, 0.01);
      check("model_const_x0_i", mi[0], 0.0, 0.01);
      check("model_const_x5_r", mr[5], 0.0, 0.01);
      repeat (112) @(posedge clk);
      #1;
      for (int n = 0; n < 32; n++) in_r[n] = n == 0 ? 256 : 0;
      load_frame(1);
      check("model_imp_x7_r", mr[7], 256.0, 0.01);
      check("model_imp_x7_i", mi[7], 0.0, 0.01);
      repeat (112) @(posedge clk);
      #1;
      for (int n = 0; n < 32; n++) in_r[n] = (n % 16) < 8 ? 127 : -127;
      load_frame(4);
      check("model_sq_x0_r", mr[0], 0.0, 0.01);
      check("model_sq_x2_r", mr[2], 508.0, 0.5);
      check("model_sq_x2_i", mi[2], -2554.0, 0.5);
      check("model_sq_x30_i", mi[30], 2554.0, 0.5);
      check("model_sq_x4_r", mr[4], 0.0, 0.01);
      repeat (112) @(posedge clk);
      #1;
      for (int f = 0; f < 3; f++) begin
         fill_random();
         load_frame(6);
         repeat (112) @(posedge clk);
         #1;
      end
      fill_random();
      load_frame(6);
      repeat (30) @(posedge clk);
      #1 rst_n = 1'b0;
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int n = 0; n < 32; n++) begin
         in_r[n] = 100;
         in_i[n] = 0;
      end
      load_frame(1);
      check("model_const100_x0_r", mr[0], 3200.0, 0.01);
      repeat (112) @(posedge clk);
      #1;
      fill_random();
      load_frame(6);
      repeat (115) @(posedge clk);
      #1;
      check("pending_bins", real'(exp_q.size()), 0.0, 0.0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
